// File: rtl/prog_seq_ctrl_pkg.sv
// prog_seq_ctrl_pkg: shared state encoding, stop opcode and default widths
package prog_seq_ctrl_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 12;
  localparam logic [3:0] STOP_OP = 4'b0011;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALT = 2'd3} state_t;
endpackage

// File: rtl/prog_seq_ctrl_ram.sv
// prog_ram: program memory, synchronous write, asynchronous read, never cleared
module prog_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_seq_ctrl.sv
// prog_seq_ctrl: loads a program RAM and sequences a processor through run/step/halt
module prog_seq_ctrl
  import prog_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              cmd_clear,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  output logic [1:0]        state,
  output logic              step_done,
  output logic [15:0]       cycle_cnt
);
  state_t st, nx;
  logic stop;
  prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (load_valid && load_ready),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (cpu_addr),
    .rdata (cpu_data)
  );
  assign load_ready = st == IDLE || st == HALT;
  assign cpu_reset  = st == IDLE;
  assign cpu_clk_en = st == RUN || st == STEP;
  assign state      = st;
  assign stop       = cpu_data[11:8] == STOP_OP;
  // halt outranks step/run even where it has no effect, so it still drops them
  always_comb begin
    nx = st;
    if (cmd_clear) nx = IDLE;
    else if (st == STEP) nx = HALT;
    else if (st == RUN) nx = (cmd_halt || stop) ? HALT : RUN;
    else if (!cmd_halt) nx = cmd_step ? STEP : cmd_run ? RUN : st;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st        <= IDLE;
      step_done <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      st        <= nx;
      step_done <= st == STEP && nx == HALT;
      cycle_cnt <= nx == IDLE ? '0 :
                   (cpu_clk_en && cycle_cnt != 16'hFFFF) ? cycle_cnt + 16'd1 : cycle_cnt;
    end
endmodule
